// File: rtl/scan_chain_pkg.sv
// scan_chain_pkg: shared types and constants for the PLL configuration
// scan-chain controller.
//   state_t      - controller FSM states
//   CMD_WRITE    - cmd_op value for a frame write
//   CMD_READBACK - cmd_op value for a frame readback
//   nbytes()     - number of host bytes needed to carry an n-bit frame
package scan_chain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_LOAD    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_UNSHIFT = 3'd5,
        ST_DRAIN   = 3'd6
    } state_t;

    localparam logic CMD_WRITE    = 1'b0;
    localparam logic CMD_READBACK = 1'b1;

    function automatic int nbytes(input int n);
        return (n + 32'sd7) / 32'sd8;
    endfunction

endpackage

// File: rtl/scan_frame_buf.sv
// scan_frame_buf: N-bit frame buffer addressed either by byte or by bit.
// Storage is padded to a whole number of bytes; padding bits may hold stale
// host data but are masked to zero on every read, so bits at index N and
// above are effectively discarded.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset (clears buffer)
//   byte_we/idx/wdata     - byte write port (byte k = bits 8k..8k+7)
//   byte_rdata            - byte read at byte_idx (padding reads as 0)
//   bit_we/idx/wdata      - bit write port
//   bit_rdata             - bit read at bit_idx
module scan_frame_buf #(
    parameter int N  = 100,
    parameter int NB = 13,
    parameter int IW = 4,
    parameter int CW = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          byte_we,
    input  logic [IW-1:0] byte_idx,
    input  logic [7:0]    byte_wdata,
    output logic [7:0]    byte_rdata,
    input  logic          bit_we,
    input  logic [CW-1:0] bit_idx,
    input  logic          bit_wdata,
    output logic          bit_rdata
);

    localparam int PW = NB * 8;
    localparam logic [PW-1:0] PAD_MASK = PW'({N{1'b1}});

    logic [PW-1:0] buf_r;
    logic [PW-1:0] vis_s;

    // Frame storage: byte writes during fill, bit writes during unshift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_r <= '0;
        end else begin
            if (byte_we) begin
                buf_r[{byte_idx, 3'b000} +: 8] <= byte_wdata;
            end
            if (bit_we) begin
                buf_r[bit_idx] <= bit_wdata;
            end
        end
    end

    // Read view with padding bits forced to zero.
    always_comb begin
        vis_s      = buf_r & PAD_MASK;
        byte_rdata = vis_s[{byte_idx, 3'b000} +: 8];
        bit_rdata  = vis_s[bit_idx];
    end

endmodule

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: frame controller for the PLL configuration shift chain.
// WRITE: collect NB host bytes, shift N bits LSB-first into the chain in one
// contiguous burst, pulse sr_load. READBACK: pulse sr_read, shift N bits out
// of the chain in one burst, return them as NB bytes.
// Ports:
//   clk, reset                    - clock (also the chain clock), async active-high reset
//   cmd_valid/cmd_op/cmd_ready    - command handshake (0 = WRITE, 1 = READBACK)
//   wr_valid/wr_data/wr_ready     - write byte stream
//   rd_valid/rd_data/rd_ready     - readback byte stream
//   sr_s_in/sr_load/sr_read       - chain serial input, load and read strobes
//   sr_s_out                      - chain serial output
//   busy, done                    - status: not idle, command-complete pulse
module scan_chain_ctrl
    import scan_chain_pkg::*;
#(
    parameter int N = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic       cmd_op,
    output logic       cmd_ready,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    input  logic       rd_ready,
    output logic       sr_s_in,
    output logic       sr_load,
    output logic       sr_read,
    input  logic       sr_s_out,
    output logic       busy,
    output logic       done
);

    localparam int NB = nbytes(N);
    localparam int CW = $clog2(N);
    localparam int IW = $clog2(NB);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NB - 1);

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [IW-1:0] idx_r;

    logic          byte_we_s;
    logic [7:0]    byte_rdata_s;
    logic          bit_we_s;
    logic          bit_rdata_s;

    scan_frame_buf #(
        .N  (N),
        .NB (NB),
        .IW (IW),
        .CW (CW)
    ) u_frame (
        .clk        (clk),
        .reset      (reset),
        .byte_we    (byte_we_s),
        .byte_idx   (idx_r),
        .byte_wdata (wr_data),
        .byte_rdata (byte_rdata_s),
        .bit_we     (bit_we_s),
        .bit_idx    (cnt_r),
        .bit_wdata  (sr_s_out),
        .bit_rdata  (bit_rdata_s)
    );

    // Controller FSM with bit counter (cnt_r) and byte index (idx_r).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            idx_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cnt_r   <= '0;
                        idx_r   <= '0;
                        state_r <= (cmd_op == CMD_WRITE) ? ST_FILL : ST_CAPTURE;
                    end
                end
                ST_FILL: begin
                    if (wr_valid) begin
                        if (idx_r == IDX_LAST) begin
                            idx_r   <= '0;
                            cnt_r   <= '0;
                            state_r <= ST_SHIFT;
                        end else begin
                            idx_r <= idx_r + IW'(1);
                        end
                    end
                end
                ST_SHIFT: begin
                    // The chain shifts every clock, so this burst never stalls.
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= '0;
                        state_r <= ST_LOAD;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_LOAD: begin
                    state_r <= ST_IDLE;
                end
                ST_CAPTURE: begin
                    cnt_r   <= '0;
                    state_r <= ST_UNSHIFT;
                end
                ST_UNSHIFT: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= '0;
                        idx_r   <= '0;
                        state_r <= ST_DRAIN;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (rd_ready) begin
                        if (idx_r == IDX_LAST) begin
                            idx_r   <= '0;
                            state_r <= ST_IDLE;
                        end else begin
                            idx_r <= idx_r + IW'(1);
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output and buffer-strobe decode from the registered state.
    always_comb begin
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = 8'h00;
        sr_s_in   = 1'b0;
        sr_load   = 1'b0;
        sr_read   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        byte_we_s = 1'b0;
        bit_we_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_FILL: begin
                wr_ready  = 1'b1;
                byte_we_s = wr_valid;
            end
            ST_SHIFT: begin
                sr_s_in = bit_rdata_s;
            end
            ST_LOAD: begin
                sr_load = 1'b1;
                done    = 1'b1;
            end
            ST_CAPTURE: begin
                sr_read = 1'b1;
            end
            ST_UNSHIFT: begin
                bit_we_s = 1'b1;
            end
            ST_DRAIN: begin
                rd_valid = 1'b1;
                rd_data  = byte_rdata_s;
                // Completion is signalled in the cycle the last byte is taken.
                done     = rd_ready && (idx_r == IDX_LAST);
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule
